fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-byte-wide fetch front end with a level-based
// memory handshake, a single output slot with stall/hold, and a two-state
// FETCH/DRAIN controller. DRAIN retires a request that was already issued
// before a jump, so the stale response is absorbed before the new fetch.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       Clk,
    input  logic       Clear,
    input  logic       Jump_Taken,
    input  logic [7:0] Jump_Address,
    input  logic       Stall,
    input  logic       Mem_Ack,
    input  logic [7:0] Mem_Data,
    output logic       Mem_Req,
    output logic [7:0] Mem_Addr,
    output logic [7:0] PC,
    output logic [7:0] Instruction,
    output logic       Inst_Valid
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic [7:0] fetch_pc;
    logic [7:0] fetch_pc_next;
    logic [7:0] redirect;
    logic [7:0] redirect_next;
    logic [7:0] pc_q;
    logic [7:0] pc_next;
    logic [7:0] inst_q;
    logic [7:0] inst_next;
    logic       valid_q;
    logic       valid_next;
    logic       transfer;
    logic       consumed;

    // Request is combinational in Clear so an asserted Clear drops it at once.
    always_comb begin
        if (state == DRAIN) begin
            Mem_Req = !Clear;
        end else begin
            Mem_Req = (!valid_q || !Stall) && !Clear;
        end
    end

    assign transfer    = Mem_Req && Mem_Ack;
    assign consumed    = valid_q && !Stall;
    assign Mem_Addr    = fetch_pc;
    assign PC          = pc_q;
    assign Instruction = inst_q;
    assign Inst_Valid  = valid_q;

    // Next-state decode: jumps outrank stalls, and a jump that meets an
    // outstanding (unacknowledged) request parks its target in redirect.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        redirect_next = redirect;
        pc_next       = pc_q;
        inst_next     = inst_q;
        valid_next    = valid_q;

        if (state == DRAIN) begin
            valid_next = 1'b0;
            if (Mem_Ack) begin
                // Stale response is dropped; a same-edge jump beats the parked one.
                fetch_pc_next = Jump_Taken ? Jump_Address : redirect;
                state_next    = FETCH;
            end else if (Jump_Taken) begin
                redirect_next = Jump_Address;
            end
        end else begin
            if (Jump_Taken) begin
                valid_next = 1'b0;
                if (Mem_Req && !Mem_Ack) begin
                    // Address must stay put until the in-flight request is acked.
                    redirect_next = Jump_Address;
                    state_next    = DRAIN;
                end else begin
                    fetch_pc_next = Jump_Address;
                end
            end else if (transfer) begin
                inst_next     = Mem_Data;
                pc_next       = fetch_pc;
                valid_next    = 1'b1;
                fetch_pc_next = fetch_pc + 8'd1;
            end else if (consumed) begin
                valid_next = 1'b0;
            end
        end
    end

    // State registers with asynchronous Clear.
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            redirect <= '0;
            pc_q     <= '0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            redirect <= redirect_next;
            pc_q     <= pc_next;
            inst_q   <= inst_next;
            valid_q  <= valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_fetch_unit;

    logic       Clk;
    logic       Clear;
    logic       Jump_Taken;
    logic [7:0] Jump_Address;
    logic       Stall;
    logic       Mem_Ack;
    logic [7:0] Mem_Data;
    logic       Mem_Req;
    logic [7:0] Mem_Addr;
    logic [7:0] PC;
    logic [7:0] Instruction;
    logic       Inst_Valid;

    logic [7:0] Mem_Data_fe;
    logic       Mem_Req_fe;
    logic [7:0] Mem_Addr_fe;
    logic [7:0] PC_fe;
    logic [7:0] Instruction_fe;
    logic       Inst_Valid_fe;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: next address to fetch, whether an issued request's
    // response must be thrown away (and where to resume), and the output slot.
    logic [7:0] m_addr;
    logic       m_stale;
    logic [7:0] m_resume;
    logic       m_valid;
    logic [7:0] m_pc;
    logic [7:0] m_inst;

    fetch_unit dut (
        .Clk(Clk), .Clear(Clear), .Jump_Taken(Jump_Taken), .Jump_Address(Jump_Address),
        .Stall(Stall), .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data), .Mem_Req(Mem_Req),
        .Mem_Addr(Mem_Addr), .PC(PC), .Instruction(Instruction), .Inst_Valid(Inst_Valid)
    );

    fetch_unit #(.RESET_PC(8'hFE)) dut_fe (
        .Clk(Clk), .Clear(Clear), .Jump_Taken(Jump_Taken), .Jump_Address(Jump_Address),
        .Stall(Stall), .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data_fe), .Mem_Req(Mem_Req_fe),
        .Mem_Addr(Mem_Addr_fe), .PC(PC_fe), .Instruction(Instruction_fe),
        .Inst_Valid(Inst_Valid_fe)
    );

    assign Mem_Data_fe = Mem_Addr_fe ^ 8'hA5;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_addr   = 8'h00;
        m_stale  = 1'b0;
        m_resume = 8'h00;
        m_valid  = 1'b0;
        m_pc     = 8'h00;
        m_inst   = 8'h00;
    endtask

    // One clock: drive inputs after the falling edge, check the request side,
    // cross the rising edge, then check the output slot.
    task automatic cycle(input logic jt, input logic [7:0] ja, input logic st,
                         input logic ack, input logic pattern, input logic [7:0] rdata);
        logic       exp_req;
        logic [7:0] d;
        d = pattern ? (m_addr ^ 8'hA5) : rdata;
        Jump_Taken   = jt;
        Jump_Address = ja;
        Stall        = st;
        Mem_Ack      = ack;
        Mem_Data     = d;
        #1;
        exp_req = m_stale || !m_valid || !st;
        check_eq("mem_req", {31'd0, Mem_Req}, {31'd0, exp_req});
        check_eq("mem_addr", {24'd0, Mem_Addr}, {24'd0, m_addr});
        @(posedge Clk);
        if (m_stale) begin
            if (jt) m_resume = ja;
            if (ack) begin
                m_addr  = m_resume;
                m_stale = 1'b0;
            end
        end else if (jt) begin
            m_valid = 1'b0;
            if (exp_req && !ack) begin
                m_stale  = 1'b1;
                m_resume = ja;
            end else begin
                m_addr = ja;
            end
        end else if (exp_req && ack) begin
            m_valid = 1'b1;
            m_pc    = m_addr;
            m_inst  = d;
            m_addr  = m_addr + 8'd1;
        end else if (m_valid && !st) begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("inst_valid", {31'd0, Inst_Valid}, {31'd0, m_valid});
        if (m_valid) begin
            check_eq("pc", {24'd0, PC}, {24'd0, m_pc});
            check_eq("instruction", {24'd0, Instruction}, {24'd0, m_inst});
        end
        @(negedge Clk);
    endtask

    initial begin
        logic [7:0] fe_exp;

        Clear        = 1'b1;
        Jump_Taken   = 1'b0;
        Jump_Address = 8'h00;
        Stall        = 1'b0;
        Mem_Ack      = 1'b0;
        Mem_Data     = 8'h00;
        model_reset();

        // Reset state
        #1;
        check_eq("rst_mem_req", {31'd0, Mem_Req}, 32'd0);
        check_eq("rst_valid", {31'd0, Inst_Valid}, 32'd0);
        check_eq("rst_pc", {24'd0, PC}, 32'd0);
        check_eq("rst_inst", {24'd0, Instruction}, 32'd0);
        check_eq("rst_addr", {24'd0, Mem_Addr}, 32'h00);
        check_eq("rst_addr_fe", {24'd0, Mem_Addr_fe}, 32'hFE);
        repeat (2) @(negedge Clk);
        Clear = 1'b0;
        Mem_Ack = 1'b1;
        #1;
        check_eq("release_req", {31'd0, Mem_Req}, 32'd1);
        check_eq("release_req_fe", {31'd0, Mem_Req_fe}, 32'd1);

        // Streaming with ack held high; also the wrap on the FE instance
        fe_exp = 8'hFE;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
            check_eq("stream_pattern", {24'd0, Instruction ^ 8'hA5}, {24'd0, m_pc});
            if (i < 4) begin
                check_eq("fe_valid", {31'd0, Inst_Valid_fe}, 32'd1);
                check_eq("fe_pc", {24'd0, PC_fe}, {24'd0, fe_exp});
                check_eq("fe_inst", {24'd0, Instruction_fe}, {24'd0, fe_exp ^ 8'hA5});
                fe_exp = fe_exp + 8'd1;
            end
        end

        // Hold under stall at PC 05, then resume with 06
        check_eq("pre_stall_pc", {24'd0, PC}, 32'h05);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00);
        check_eq("stall_hold_pc", {24'd0, PC}, 32'h05);
        check_eq("stall_hold_inst", {24'd0, Instruction}, 32'h05 ^ 32'hA5);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("post_stall_pc", {24'd0, PC}, 32'h06);

        // Jump meets an unacked request: drain, then redirect to 40
        cycle(1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 8'h40, 1'b0, 1'b0, 1'b1, 8'h00);
        check_eq("drain_addr_hold", {24'd0, Mem_Addr}, 32'h10);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
        check_eq("drain_addr_hold2", {24'd0, Mem_Addr}, 32'h10);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C);
        check_eq("drain_exit_addr", {24'd0, Mem_Addr}, 32'h40);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("redirect_pc", {24'd0, PC}, 32'h40);

        // Latest jump wins while draining
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("latest_jump_addr", {24'd0, Mem_Addr}, 32'h66);

        // Jump on the same edge as a transfer from 20
        cycle(1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 8'h00);
        cycle(1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("jump_xfer_valid", {31'd0, Inst_Valid}, 32'd0);
        check_eq("jump_xfer_addr", {24'd0, Mem_Addr}, 32'h80);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("jump_xfer_pc", {24'd0, PC}, 32'h80);

        // Clear asserted between edges while draining
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h00);
        #2;
        Clear = 1'b1;
        #1;
        check_eq("clr_mem_req", {31'd0, Mem_Req}, 32'd0);
        check_eq("clr_valid", {31'd0, Inst_Valid}, 32'd0);
        check_eq("clr_addr", {24'd0, Mem_Addr}, 32'h00);
        check_eq("clr_pc", {24'd0, PC}, 32'd0);
        model_reset();
        @(negedge Clk);
        Clear = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("post_clr_pc", {24'd0, PC}, 32'h00);
        check_eq("post_clr_addr", {24'd0, Mem_Addr}, 32'h01);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 99) < 15), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 60),
                  1'b0, 8'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
